key_pio_poller: RTL and testbench

- Avalon-MM master that polls the read-only key PIO slave (address 0, bit 0 = raw key pin; registered readdata, one-cycle read latency, no waitrequest).
- Issues periodic reads, debounces the sampled key bit, and produces a clean level, one-cycle press/release strobes and a press counter.
- Sits between the camera module's key PIO slave and the capture-control logic, replacing software polling.

---
 rtl/key_pio_poller.sv | 135 +++++++++++++
 tb/tb_key_pio_poller.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_pio_poller.sv
// Avalon-MM master that periodically reads the key PIO, debounces bit 0 and
// reports a clean level, press/release strobes and a wrapping press counter.
`timescale 1ns/1ps
module key_pio_poller #(
  parameter int POLL_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int READ_LATENCY = 1,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        key_level,
  output logic        key_press,
  output logic        key_release,
  output logic [15:0] press_count,
  output logic        overrun
);

  localparam int                 TIMER_W      = 20;
  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(POLL_DIV - 1);
  localparam logic [1:0]         LAT_RELOAD   = 2'(READ_LATENCY - 1);
  localparam logic [3:0]         DB_THRESH    = 4'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {IDLE, REQ, LAT, CAPTURE} state_t;

  state_t             state, state_next;
  logic [TIMER_W-1:0] timer;
  logic               tick;
  logic [1:0]         lat_cnt, lat_cnt_next;
  logic               sample;
  logic               candidate, candidate_next;
  logic [3:0]         stable_cnt, stable_cnt_next;
  logic               accept;
  logic               readdata_unused;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  assign tick            = enable && (timer == '0);
  assign avm_read        = (state == REQ);
  assign avm_address     = 2'b00;
  assign readdata_unused = ^avm_readdata[31:1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= TIMER_RELOAD;
    end else if (!enable || timer == '0) begin
      timer <= TIMER_RELOAD;
    end else begin
      timer <= timer - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      lat_cnt <= '0;
    end else begin
      state   <= state_next;
      lat_cnt <= lat_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    lat_cnt_next = lat_cnt;
    case (state)
      IDLE:    if (tick) state_next = REQ;
      REQ: begin
        if (!avm_waitrequest) begin
          lat_cnt_next = LAT_RELOAD;
          state_next   = LAT;
        end
      end
      LAT: begin
        if (lat_cnt == '0) state_next = CAPTURE;
        else               lat_cnt_next = lat_cnt - 1'b1;
      end
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Readdata is valid on the last latency cycle; normalise to 1 = pressed.
  always_ff @(posedge clk) begin
    if (state == LAT && lat_cnt == '0) sample <= avm_readdata[0] ^ ACTIVE_LOW;
  end

  always_comb begin
    candidate_next  = candidate;
    stable_cnt_next = stable_cnt;
    accept          = 1'b0;
    if (state == CAPTURE) begin
      if (sample == candidate) begin
        stable_cnt_next = sat_inc(stable_cnt);
      end else begin
        candidate_next  = sample;
        stable_cnt_next = 4'd1;
      end
      accept = (stable_cnt_next >= DB_THRESH) && (candidate_next != key_level);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      candidate   <= 1'b0;
      stable_cnt  <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      press_count <= '0;
      overrun     <= 1'b0;
    end else begin
      candidate   <= candidate_next;
      stable_cnt  <= stable_cnt_next;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      if (accept) begin
        key_level   <= candidate_next;
        key_press   <= candidate_next;
        key_release <= ~candidate_next;
        if (candidate_next) press_count <= press_count + 16'd1;
      end
      // A tick that finds a read still in flight is dropped but remembered.
      if (tick && state != IDLE) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_key_pio_poller.sv
// Bench for key_pio_poller: PIO slave model plus a sample-history debounce
// reference, driven with directed and random key waveforms.
`timescale 1ns/1ps
module tb_key_pio_poller;

  localparam int POLL_DIV = 8;
  localparam int DB       = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        key_level, key_press, key_release, overrun;
  logic [15:0] press_count;

  logic        key_pin = 1'b1;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_acc = -1;
  bit          hist[$];
  bit          m_level = 1'b0;
  logic [15:0] m_count = '0;

  key_pio_poller #(
    .POLL_DIV(POLL_DIV), .DEBOUNCE_CNT(DB), .READ_LATENCY(1), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .key_level(key_level), .key_press(key_press), .key_release(key_release),
    .press_count(press_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered PIO slave: bit 0 is the pin, upper bits are noise.
  always @(posedge clk)
    if (avm_read && !avm_waitrequest)
      avm_readdata <= ($urandom() & 32'hFFFF_FFFE) | {31'd0, key_pin};

  // A new level is accepted when the last DB samples all agree and differ.
  function automatic void model_sample(input bit pressed, output bit ep, output bit er);
    bit all_eq = 1'b1;
    ep = 1'b0;
    er = 1'b0;
    hist.push_back(pressed);
    if (hist.size() >= DB) begin
      for (int i = hist.size() - DB; i < hist.size(); i++)
        if (hist[i] != pressed) all_eq = 1'b0;
      if (all_eq && pressed != m_level) begin
        m_level = pressed;
        ep = pressed;
        er = !pressed;
        if (pressed) m_count = m_count + 16'd1;
      end
    end
  endfunction

  function automatic void model_reset();
    hist.delete();
    m_level = 1'b0;
    m_count = '0;
  endfunction

  task automatic wait_read(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (avm_read && !avm_waitrequest) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Drives the pin, waits for the accepted read and returns three cycles later.
  task automatic run_poll(input bit raw, output int gap);
    bit ok;
    key_pin = raw;
    wait_read(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL read_timeout: no accepted read within 200 cycles, want one every %0d", POLL_DIV);
    end
    gap = (last_acc < 0) ? -1 : cyc - last_acc;
    last_acc = cyc;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if (avm_read !== 1'b0 || avm_address !== 2'b00 || key_level !== 1'b0 || key_press !== 1'b0 ||
          key_release !== 1'b0 || press_count !== 16'd0 || overrun !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: read=%b addr=%0d level=%b press=%b rel=%b count=%h ovr=%b, want all 0",
                 i, avm_read, avm_address, key_level, key_press, key_release, press_count, overrun);
      end
    end
  endtask

  task automatic test_clean_press();
    bit seq[10] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
    bit ep, er;
    int gap;
    enable = 1'b1;
    last_acc = -1;
    for (int i = 0; i < 10; i++) begin
      run_poll(seq[i], gap);
      model_sample(!seq[i], ep, er);
      checks++;
      if (key_level !== m_level || key_press !== ep || key_release !== er || press_count !== m_count) begin
        errors++;
        $display("FAIL clean_press poll %0d: level=%b press=%b rel=%b count=%h, want %b %b %b %h",
                 i, key_level, key_press, key_release, press_count, m_level, ep, er, m_count);
      end
      if (gap >= 0) begin
        checks++;
        if (gap != POLL_DIV) begin
          errors++;
          $display("FAIL poll_period poll %0d: %0d cycles, want %0d", i, gap, POLL_DIV);
        end
      end
      if (i == 5) begin
        checks++;
        if (key_press !== 1'b1 || press_count !== 16'd1) begin
          errors++;
          $display("FAIL press_on_4th: press=%b count=%h, want 1 0001", key_press, press_count);
        end
      end
      @(negedge clk);
      checks++;
      if (key_press !== 1'b0 || key_release !== 1'b0) begin
        errors++;
        $display("FAIL strobe_width poll %0d: press=%b rel=%b, want 0 0", i, key_press, key_release);
      end
    end
  endtask

  task automatic test_bounce();
    bit seq[8] = '{0, 1, 0, 1, 0, 0, 0, 0};
    bit ep, er;
    int gap, npress, nrel;
    npress = 0;
    nrel = 0;
    for (int i = 0; i < 8; i++) begin
      run_poll(seq[i], gap);
      model_sample(!seq[i], ep, er);
      npress += int'(key_press === 1'b1);
      nrel   += int'(key_release === 1'b1);
      checks++;
      if (key_level !== m_level || key_press !== ep || key_release !== er || press_count !== m_count) begin
        errors++;
        $display("FAIL bounce poll %0d: level=%b press=%b rel=%b count=%h, want %b %b %b %h",
                 i, key_level, key_press, key_release, press_count, m_level, ep, er, m_count);
      end
      @(negedge clk);
    end
    checks++;
    if (npress != 1 || nrel != 0 || key_level !== 1'b1) begin
      errors++;
      $display("FAIL bounce_total: presses=%0d releases=%0d level=%b, want 1 0 1", npress, nrel, key_level);
    end
  endtask

  task automatic test_random();
    bit raw, ep, er;
    int gap;
    raw = key_pin;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) raw = ~raw;
      run_poll(raw, gap);
      model_sample(!raw, ep, er);
      checks++;
      if (key_level !== m_level || key_press !== ep || key_release !== er || press_count !== m_count) begin
        errors++;
        $display("FAIL random poll %0d: level=%b press=%b rel=%b count=%h, want %b %b %b %h",
                 i, key_level, key_press, key_release, press_count, m_level, ep, er, m_count);
      end
      checks++;
      if (gap != POLL_DIV) begin
        errors++;
        $display("FAIL random_period poll %0d: %0d cycles, want %0d", i, gap, POLL_DIV);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    bit ep, er;
    int gap;
    for (int i = 0; i < 12; i++) begin
      bit raw;
      raw = (i < 4) ? 1'b1 : (i < 8) ? 1'b0 : 1'b1;
      run_poll(raw, gap);
      model_sample(!raw, ep, er);
      checks++;
      if (key_level !== m_level || key_press !== ep || key_release !== er || press_count !== m_count) begin
        errors++;
        $display("FAIL wrap poll %0d: level=%b press=%b rel=%b count=%h, want %b %b %b %h",
                 i, key_level, key_press, key_release, press_count, m_level, ep, er, m_count);
      end
      @(negedge clk);
      if (i == 3) begin
        force dut.press_count = 16'hFFFF;
        @(negedge clk);
        release dut.press_count;
        m_count = 16'hFFFF;
      end
      if (i == 7) begin
        checks++;
        if (press_count !== 16'h0000 || key_level !== 1'b1) begin
          errors++;
          $display("FAIL wrap_count: count=%h level=%b, want 0000 1", press_count, key_level);
        end
      end
    end
    checks++;
    if (key_level !== 1'b0) begin
      errors++;
      $display("FAIL wrap_release: level=%b, want 0", key_level);
    end
  endtask

  task automatic test_stall();
    bit raw, ep, er, ok;
    int gap;
    raw = m_level ? 1'b1 : 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: overrun=%b, want 0", overrun);
    end
    for (int i = 0; i < 3; i++) begin
      run_poll(raw, gap);
      model_sample(!raw, ep, er);
      @(negedge clk);
    end
    avm_waitrequest = 1'b1;
    key_pin = raw;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = avm_read;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_req_timeout: avm_read never rose, want 1");
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (avm_read !== 1'b1 || avm_address !== 2'b00) begin
        errors++;
        $display("FAIL stall_hold cycle %0d: read=%b addr=%0d, want 1 0", i, avm_read, avm_address);
      end
      @(negedge clk);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL stall_overrun: overrun=%b, want 1", overrun);
    end
    avm_waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    model_sample(!raw, ep, er);
    checks++;
    if (key_level !== m_level || key_press !== ep || key_release !== er || press_count !== m_count) begin
      errors++;
      $display("FAIL stall_capture: level=%b press=%b rel=%b count=%h, want %b %b %b %h",
               key_level, key_press, key_release, press_count, m_level, ep, er, m_count);
    end
    last_acc = -1;
    repeat (20) @(negedge clk);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: overrun=%b, want 1", overrun);
    end
  endtask

  task automatic test_enable_mid();
    bit raw, ep, er, ok;
    int gap, nreads;
    raw = m_level ? 1'b1 : 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_poll(raw, gap);
      model_sample(!raw, ep, er);
      @(negedge clk);
    end
    key_pin = raw;
    wait_read(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL enable_mid_timeout: no accepted read, want one");
    end
    @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    model_sample(!raw, ep, er);
    checks++;
    if (key_level !== m_level || key_press !== ep || key_release !== er || press_count !== m_count) begin
      errors++;
      $display("FAIL enable_mid_capture: level=%b press=%b rel=%b count=%h, want %b %b %b %h",
               key_level, key_press, key_release, press_count, m_level, ep, er, m_count);
    end
    nreads = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      nreads += int'(avm_read === 1'b1);
    end
    checks++;
    if (nreads != 0) begin
      errors++;
      $display("FAIL enable_off_reads: %0d read cycles, want 0", nreads);
    end
    enable = 1'b1;
    last_acc = -1;
    for (int i = 0; i < 3; i++) begin
      raw = 1'($urandom_range(0, 1));
      run_poll(raw, gap);
      model_sample(!raw, ep, er);
      checks++;
      if (key_level !== m_level || key_press !== ep || key_release !== er || press_count !== m_count) begin
        errors++;
        $display("FAIL reenable poll %0d: level=%b press=%b rel=%b count=%h, want %b %b %b %h",
                 i, key_level, key_press, key_release, press_count, m_level, ep, er, m_count);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    bit ep, er, ok;
    int gap;
    checks++;
    if (press_count === 16'd0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_state: count=%h ovr=%b, want nonzero 1", press_count, overrun);
    end
    avm_waitrequest = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = avm_read;
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (!ok || avm_read !== 1'b0 || press_count !== 16'd0 || key_level !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: seen_req=%b read=%b count=%h level=%b ovr=%b, want 1 0 0000 0 0",
               ok, avm_read, press_count, key_level, overrun);
    end
    avm_waitrequest = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    last_acc = -1;
    for (int i = 0; i < 4; i++) begin
      run_poll(1'b0, gap);
      model_sample(1'b1, ep, er);
      checks++;
      if (key_level !== m_level || key_press !== ep || key_release !== er || press_count !== m_count) begin
        errors++;
        $display("FAIL post_reset poll %0d: level=%b press=%b rel=%b count=%h, want %b %b %b %h",
                 i, key_level, key_press, key_release, press_count, m_level, ep, er, m_count);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_random();
    test_wrap();
    test_stall();
    test_enable_mid();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
